instruction_encoder: RTL

//  Inverse of the instruction field decoder: packs opcode/regD/regS/regT/offset into 23-bit words.

---
 rtl/instruction_encoder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// instruction_encoder
// Packs opcode/regD/regS/regT/offset field tuples into 23-bit instruction
// words and streams them into instruction memory at consecutive addresses.
// This is the program-loader path that mirrors the instruction field decoder.
//
// Optional feature: define INSTR_ENC_PARITY_EN to add the mem_wparity output
// (even parity over the 23 packed bits, registered alongside mem_wdata).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start, done     1-cycle pulses that begin / end a load (start wins)
//   in_valid        field tuple valid
//   in_ready        tuple can be accepted this cycle
//   opcode..offset  instruction fields, packed as {opcode,regD,regS,regT,offset}
//   mem_we          write strobe, high for one cycle per legal word
//   mem_addr        write address (holds last value between writes)
//   mem_wdata       packed instruction (holds last value between writes)
//   word_count      words written since the last start (saturating)
//   busy            loader is accepting words
//   full            memory capacity reached (held until the next start)
//   err_opcode      sticky: an illegal opcode was consumed and dropped
//   mem_wparity     (INSTR_ENC_PARITY_EN only) parity of mem_wdata
module instruction_encoder #(
    parameter int ADDR_W      = 6,
    parameter int NUM_OPCODES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [1:0]        regD,
    input  logic [1:0]        regS,
    input  logic [1:0]        regT,
    input  logic [11:0]       offset,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [22:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              full,
`ifdef INSTR_ENC_PARITY_EN
    output logic              mem_wparity,
`endif
    output logic              err_opcode
);

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
    // Six bits so that NUM_OPCODES = 32 (every opcode legal) is representable.
    localparam logic [5:0]        OPC_LIMIT = 6'(NUM_OPCODES);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W:0]     count_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [22:0]         mem_wdata_reg;
    logic                full_reg;
    logic                err_reg;

    logic [22:0]         packed_word;
    logic                accept;
    logic                legal;
    logic                write_now;
    logic                last_write;

    assign packed_word = {opcode, regD, regS, regT, offset};
    assign accept      = in_valid && in_ready;
    assign legal       = ({1'b0, opcode} < OPC_LIMIT);
    assign write_now   = accept && legal;
    assign last_write  = write_now && (wr_ptr_reg == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // in_ready is withheld during a start cycle so that a restart never
    // races with a tuple handshake; the restart begins from a clean pointer.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                in_ready = !start;
                if (start)           state_next = LOAD;
                else if (done)       state_next = IDLE;
                else if (last_write) state_next = FULL;
            end
            FULL: begin
                if (start)     state_next = LOAD;
                else if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath. A write registered in the previous cycle is already on the
    // outputs, so a restart cannot disturb it; it finishes at its old address.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            full_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            mem_we_reg <= write_now;
            if (write_now) begin
                mem_addr_reg  <= wr_ptr_reg;
                mem_wdata_reg <= packed_word;
                wr_ptr_reg    <= wr_ptr_reg + 1'b1;
                if (count_reg != CAPACITY) count_reg <= count_reg + 1'b1;
                if (last_write) full_reg <= 1'b1;
            end
            if (accept && !legal) err_reg <= 1'b1;
            if (start) begin
                wr_ptr_reg <= '0;
                count_reg  <= '0;
                full_reg   <= 1'b0;
                err_reg    <= 1'b0;
            end
        end
    end

`ifdef INSTR_ENC_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (write_now) begin
            parity_reg <= ^packed_word;
        end
    end

    assign mem_wparity = parity_reg;
`endif

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign word_count = count_reg;
    assign busy       = (state_reg == LOAD);
    assign full       = full_reg;
    assign err_opcode = err_reg;

endmodule
